// File: rtl/fp_rs_pipe_pkg.sv
// -----------------------------------------------------------------------------
// fp_rs_pipe_pkg
// Shared types for the FP reservation station: the operand and entry records
// held in the station, the CDB broadcast record, the ROB tag width and the
// tag_match() helper used by both issue-time bypass and entry wakeup.
// No ports (package).
// -----------------------------------------------------------------------------
package fp_rs_pipe_pkg;

   localparam int ROB_WIDTH = 5;  // ROB tag width
   localparam int OP_W_MAX  = 4;  // widest opcode an entry can hold

   typedef struct packed {
      logic                 valid;
      logic [ROB_WIDTH-1:0] tag;   // producer tag while waiting
      logic [31:0]          data;
   } rs_opd_t;

   typedef struct packed {
      logic                 valid;
      logic [ROB_WIDTH-1:0] tag;   // destination ROB tag
      logic [OP_W_MAX-1:0]  op;
      rs_opd_t [1:0]        opd;
   } rs_entry_t;

   typedef struct packed {
      logic                 valid;
      logic [ROB_WIDTH-1:0] tag;
      logic [31:0]          data;
   } rs_cdb_t;

   // True when the broadcast on the CDB produces the operand waiting on 'tag'.
   function automatic logic tag_match(input rs_cdb_t cdb, input logic [ROB_WIDTH-1:0] tag);
      return cdb.valid && (cdb.tag == tag);
   endfunction

endpackage

// File: rtl/fp_rs_pipe_if.sv
// -----------------------------------------------------------------------------
// fp_rs_pipe_if
// Bundles the station's issue, CDB snoop, dispatch, done and flush signals.
//   master : FP issue logic / CDB / core side (drives issue_*, cdb_*,
//            disp_ready, flush)
//   slave  : the reservation station (drives issue_ready, disp_*, done_*,
//            occupancy)
// -----------------------------------------------------------------------------
interface fp_rs_pipe_if
   import fp_rs_pipe_pkg::*;
#(
   parameter int N_ENTRY = 4,
   parameter int TAG_W   = ROB_WIDTH,
   parameter int OP_W    = 1
) ();

   logic                         flush;

   logic                         issue_valid;
   logic                         issue_ready;
   logic [TAG_W-1:0]             issue_tag;
   logic [OP_W-1:0]              issue_op;
   logic [1:0]                   issue_opd_valid;
   logic [2*TAG_W-1:0]           issue_opd_tag;   // [TAG_W-1:0] = opd0
   logic [63:0]                  issue_opd_data;  // [31:0] = opd0

   logic                         cdb_valid;
   logic [TAG_W-1:0]             cdb_tag;
   logic [31:0]                  cdb_data;

   logic                         disp_valid;
   logic                         disp_ready;
   logic [TAG_W-1:0]             disp_tag;
   logic [OP_W-1:0]              disp_op;
   logic [31:0]                  disp_opd_a;
   logic [31:0]                  disp_opd_b;

   logic                         done_valid;
   logic [TAG_W-1:0]             done_tag;

   logic [$clog2(N_ENTRY+1)-1:0] occupancy;

   modport master (
      output flush, issue_valid, issue_tag, issue_op, issue_opd_valid,
             issue_opd_tag, issue_opd_data, cdb_valid, cdb_tag, cdb_data,
             disp_ready,
      input  issue_ready, disp_valid, disp_tag, disp_op, disp_opd_a,
             disp_opd_b, done_valid, done_tag, occupancy
   );

   modport slave (
      input  flush, issue_valid, issue_tag, issue_op, issue_opd_valid,
             issue_opd_tag, issue_opd_data, cdb_valid, cdb_tag, cdb_data,
             disp_ready,
      output issue_ready, disp_valid, disp_tag, disp_op, disp_opd_a,
             disp_opd_b, done_valid, done_tag, occupancy
   );

endinterface

// File: rtl/fp_rs_pipe_tag_pipe.sv
// -----------------------------------------------------------------------------
// rs_tag_pipe
// LATENCY-stage {valid, tag} shift register that travels alongside the FP
// core so the ROB tag emerges in the same cycle as the core result.
//   clk, reset  : clock, asynchronous active-high reset
//   flush       : synchronous clear of every valid bit (priority over load)
//   in_valid/in_tag   : stage 0 load (dispatch)
//   out_valid/out_tag : last stage
// -----------------------------------------------------------------------------
module rs_tag_pipe #(
   parameter int LATENCY = 4,
   parameter int TAG_W   = 5
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             flush,
   input  logic             in_valid,
   input  logic [TAG_W-1:0] in_tag,
   output logic             out_valid,
   output logic [TAG_W-1:0] out_tag
);

   logic [LATENCY-1:0] vld;
   logic [TAG_W-1:0]   tag [LATENCY];

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         vld <= '0;
         for (int i = 0; i < LATENCY; i++) tag[i] <= '0;
      end else begin
         // Flush only kills the valid bits; the tags left behind are don't-care.
         vld[0] <= in_valid && !flush;
         tag[0] <= in_tag;
         for (int i = 1; i < LATENCY; i++) begin
            vld[i] <= vld[i-1] && !flush;
            tag[i] <= tag[i-1];
         end
      end
   end

   assign out_valid = vld[LATENCY-1];
   assign out_tag   = tag[LATENCY-1];

endmodule

// File: rtl/fp_rs_pipe.sv
// -----------------------------------------------------------------------------
// fp_rs_pipe
// Compacting reservation station for a two-operand, fixed-latency FP unit.
// Entries are kept oldest-first at index 0; the oldest entry with both
// operands present is offered on disp_*, operands wake up from the FP CDB,
// and a tag pipeline aligns done_tag with the core result.
//   clk, reset : clock, asynchronous active-high reset
//   bus        : fp_rs_pipe_if.slave (issue, CDB snoop, dispatch, done,
//                flush, occupancy)
// Build option: RS_ISSUE_BYPASS_EN -- capture a same-cycle CDB broadcast
// into a newly accepted entry's missing operand.
// -----------------------------------------------------------------------------
module fp_rs_pipe
   import fp_rs_pipe_pkg::*;
#(
   parameter int N_ENTRY = 4,
   parameter int OP_W    = 1,
   parameter int LATENCY = 4,
   parameter int TAG_W   = ROB_WIDTH
) (
   input  logic         clk,
   input  logic         reset,
   fp_rs_pipe_if.slave  bus
);

   localparam int CNT_W = $clog2(N_ENTRY+1);
   localparam int IDX_W = $clog2(N_ENTRY);

   rs_entry_t        e     [N_ENTRY];
   rs_entry_t        e_nxt [N_ENTRY];
   rs_entry_t        e_ext [N_ENTRY+1];   // e plus an empty slot shifted in at the top
   rs_entry_t        new_e;
   rs_cdb_t          cdb;
   logic [CNT_W-1:0] count, count_nxt;
   logic [IDX_W-1:0] sel, wr_idx;
   logic             found, dispatch, accept;

   assign cdb = '{valid: bus.cdb_valid, tag: ROB_WIDTH'(bus.cdb_tag), data: bus.cdb_data};

   // Oldest ready entry, from registered state only, so a CDB match this cycle
   // cannot make an entry eligible before the next cycle.
   always_comb begin
      // NOTE: every always_comb output gets a default first so no latch is inferred.
      found = 1'b0;
      sel   = '0;
      for (int i = N_ENTRY-1; i >= 0; i--) begin
         if (e[i].valid && e[i].opd[0].valid && e[i].opd[1].valid) begin
            found = 1'b1;
            sel   = IDX_W'(i);
         end
      end
   end

   assign dispatch        = found && bus.disp_ready;
   assign bus.issue_ready = (count < CNT_W'(N_ENTRY)) || dispatch;
   assign accept          = bus.issue_valid && bus.issue_ready;

   // Incoming entry as presented by the issuer.
   always_comb begin
      new_e       = '0;
      new_e.valid = 1'b1;
      new_e.tag   = ROB_WIDTH'(bus.issue_tag);
      new_e.op    = OP_W_MAX'(bus.issue_op);
      for (int j = 0; j < 2; j++) begin
         new_e.opd[j].valid = bus.issue_opd_valid[j];
         new_e.opd[j].tag   = ROB_WIDTH'(bus.issue_opd_tag[j*TAG_W +: TAG_W]);
         new_e.opd[j].data  = bus.issue_opd_data[j*32 +: 32];
`ifdef RS_ISSUE_BYPASS_EN
         if (!new_e.opd[j].valid && tag_match(cdb, new_e.opd[j].tag)) begin
            new_e.opd[j].valid = 1'b1;
            new_e.opd[j].data  = cdb.data;
         end
`endif
      end
   end

   // Next state: remove e[sel] by shifting the younger entries down, wake up
   // retained entries from the CDB, then append the new entry at the tail.
   always_comb begin
      for (int i = 0; i < N_ENTRY; i++) e_ext[i] = e[i];
      e_ext[N_ENTRY] = '0;

      for (int i = 0; i < N_ENTRY; i++) begin
         e_nxt[i] = (dispatch && (IDX_W'(i) >= sel)) ? e_ext[i+1] : e_ext[i];
         for (int j = 0; j < 2; j++) begin
            if (e_nxt[i].valid && !e_nxt[i].opd[j].valid && tag_match(cdb, e_nxt[i].opd[j].tag)) begin
               e_nxt[i].opd[j].valid = 1'b1;
               e_nxt[i].opd[j].data  = cdb.data;
            end
         end
      end

      // Tail slot moves down by one when an entry leaves in the same cycle.
      wr_idx = IDX_W'(count - CNT_W'(dispatch));
      if (accept) e_nxt[wr_idx] = new_e;

      count_nxt = count + CNT_W'(accept) - CNT_W'(dispatch);
   end

   // NOTE: sequential state uses non-blocking assignments only, so every
   // register samples the pre-edge value of every other.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         // NOTE: the whole entry array is reset, not just the valid bits; at
         // this depth it is cheap and keeps X off the disp_* outputs.
         for (int i = 0; i < N_ENTRY; i++) e[i] <= '0;
         count <= '0;
      end else if (bus.flush) begin
         for (int i = 0; i < N_ENTRY; i++) e[i] <= '0;
         count <= '0;
      end else begin
         for (int i = 0; i < N_ENTRY; i++) e[i] <= e_nxt[i];
         count <= count_nxt;
      end
   end

   assign bus.disp_valid = found;
   assign bus.disp_tag   = TAG_W'(e[sel].tag);
   assign bus.disp_op    = OP_W'(e[sel].op);
   assign bus.disp_opd_a = e[sel].opd[0].data;
   assign bus.disp_opd_b = e[sel].opd[1].data;
   assign bus.occupancy  = count;

   rs_tag_pipe #(
      .LATENCY (LATENCY),
      .TAG_W   (TAG_W)
   ) u_tag_pipe (
      .clk       (clk),
      .reset     (reset),
      .flush     (bus.flush),
      .in_valid  (dispatch),
      .in_tag    (bus.disp_tag),
      .out_valid (bus.done_valid),
      .out_tag   (bus.done_tag)
   );

endmodule
